// File: rtl/axi4_default_err_slave_pkg.sv
// axi4_default_err_slave_pkg: response codes and FSM state types for the default error slave
package axi4_default_err_slave_pkg;
  localparam logic [1:0] ERR_RESP_OKAY   = 2'b00;
  localparam logic [1:0] ERR_RESP_SLVERR = 2'b10;
  localparam logic [1:0] ERR_RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi4_default_err_slave.sv
// axi4_default_err_slave: answers every AXI4 write/read on unmapped space with a fixed error response
module axi4_default_err_slave
  import axi4_default_err_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH = 8,
  parameter logic [1:0] ERR_RESP = ERR_RESP_DECERR,
  parameter logic [DATA_WIDTH-1:0] RDATA_FILL = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);
  w_state_t w_state;
  r_state_t r_state;
  logic [7:0] beat_cnt;
  logic [7:0] len;
  assign bresp = ERR_RESP;
  assign rresp = ERR_RESP;
  assign rdata = RDATA_FILL;
  // awready is held low in the release cycle and raised by the first edge in W_IDLE
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE:
          if (awvalid && awready) begin
            bid     <= awid;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else awready <= 1'b1;
        W_DATA:
          if (wvalid && wready && wlast) begin
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            w_state <= W_RESP;
          end
        default:
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
      endcase
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      beat_cnt <= '0;
      len      <= '0;
    end else begin
      case (r_state)
        R_IDLE:
          if (arvalid && arready) begin
            rid      <= arid;
            len      <= arlen;
            beat_cnt <= '0;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rlast    <= (arlen == 8'd0);
            r_state  <= R_DATA;
          end else arready <= 1'b1;
        default:
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              rlast    <= (beat_cnt + 8'd1 == len);
            end
          end
      endcase
    end
  end
endmodule
